spi_master_pi: RTL

SPI_MASTER_PI -- requirements
Module: spi_master_pi

---
 rtl/spi_master_pi_if.sv | 24 ++
 rtl/spi_master_pi.sv | 127 ++++++++++++
 2 files changed

// File: rtl/spi_master_pi_if.sv
// rtl/spi_master_pi_if.sv - control and SPI pin bundle for spi_master_pi
interface spi_master_pi_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_ss_n;

    modport master (
        input  start, tx_data, spi_miso,
        output busy, done, rx_data, spi_sclk, spi_mosi, spi_ss_n
    );

    modport slave (
        output start, tx_data, spi_miso,
        input  busy, done, rx_data, spi_sclk, spi_mosi, spi_ss_n
    );
endinterface

// File: rtl/spi_master_pi.sv
// rtl/spi_master_pi.sv - mode-0 SPI master, one frame per accepted start
module spi_master_pi #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    spi_master_pi_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_busy;
    logic              r_done;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_ss_n;

    logic w_div_end;
    logic w_bit_last;

    assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_bit_last = (r_bit == BIT_W'(DATA_W - 1));

    // Every phase (setup, each SCLK half, hold, gap) is one full divider period.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ss_n    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_tx    <= bus.tx_data;
                        r_mosi  <= bus.tx_data[DATA_W-1];
                        r_busy  <= 1'b1;
                        r_ss_n  <= 1'b0;
                        r_div   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b1;
                        r_rx    <= {r_rx[DATA_W-2:0], bus.spi_miso};
                        r_state <= S_XFER;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            if (w_bit_last) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit  <= r_bit + BIT_W'(1);
                                r_mosi <= r_tx[DATA_W-2];
                                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[DATA_W-2:0], bus.spi_miso};
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_div     <= '0;
                        r_ss_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        r_state   <= S_GAP;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rx_data  = r_rx_data;
    assign bus.spi_sclk = r_sclk;
    assign bus.spi_mosi = r_mosi;
    assign bus.spi_ss_n = r_ss_n;
endmodule
